alu4_arbiter: RTL

- Shares one 4-bit ALU datapath between two requesters, each using a valid/ready request channel.
- Round-robin arbitration decides which requester is served next.
- Handles one operation at a time: capture operands, execute with a registered result, then hold the response until it is accepted.
- Sits between the two issuing units and the ALU function; keeps a wrapping per-requester completion counter.

---
 rtl/alu4_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu4_arbiter.sv
// Two-requester round-robin front end for a shared 4-bit ALU.
// Runs one operation at a time: accept, execute into registers, then hold the response
// until it is taken. Keeps a wrapping completion counter for each requester.
module alu4_arbiter #(
  parameter int unsigned PRIO_INIT = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [3:0]       resp_result,
  output logic             resp_carry,
  output logic             resp_overflow,
  output logic             resp_zero,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  // last_served starts on the other requester so PRIO_INIT wins the first contended grant.
  localparam logic LastInit = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

  state_e           state_q, state_d;
  logic             last_q;
  logic [2:0]       op_q;
  logic [3:0]       a_q, b_q;
  logic             id_q;
  logic [3:0]       result_q;
  logic             carry_q, ovf_q, zero_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  logic             gnt0, gnt1, accept, accept_id;
  logic [3:0]       alu_res;
  logic             alu_c, alu_v, alu_z;

  // Round-robin grant; ready is combinational from the valids and is forced low in reset.
  always_comb begin
    gnt0       = req0_valid && (!req1_valid || last_q);
    gnt1       = req1_valid && (!req0_valid || !last_q);
    req0_ready = rst_n && (state_q == StIdle) && gnt0;
    req1_ready = rst_n && (state_q == StIdle) && gnt1;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    accept_id  = req1_ready;
  end

  // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP, RESP -> IDLE on handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ALU on the captured operands; subtract-type ops use the two's complement of b.
  always_comb begin
    logic       use_neg;
    logic [3:0] bp;
    logic [4:0] sum;
    use_neg = (op_q == 3'b001) || (op_q[2:1] == 2'b11);
    bp      = use_neg ? (~b_q + 4'd1) : b_q;
    sum     = {1'b0, a_q} + {1'b0, bp};
    alu_v   = (a_q[3] == bp[3]) && (a_q[3] != sum[3]);
    alu_z   = (sum[3:0] == 4'd0);
    alu_c   = sum[4];
    alu_res = sum[3:0];
    unique case (op_q)
      3'b000, 3'b001: alu_res = sum[3:0];
      3'b010: begin alu_res = a_q ^ 4'hF; alu_c = 1'b0; alu_v = 1'b0; end
      3'b011: begin alu_res = a_q & bp;   alu_c = 1'b0; alu_v = 1'b0; end
      3'b100: begin alu_res = a_q | bp;   alu_c = 1'b0; alu_v = 1'b0; end
      3'b101: begin alu_res = a_q ^ bp;   alu_c = 1'b0; alu_v = 1'b0; end
      3'b110: alu_res = {3'b000, sum[3] ^ alu_v};
      3'b111: alu_res = {3'b000, alu_z};
      default: alu_res = sum[3:0];
    endcase
  end

  // State, operand capture, registered result and completion counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_q   <= LastInit;
      op_q     <= 3'd0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      id_q     <= 1'b0;
      result_q <= 4'd0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= accept_id ? req1_op : req0_op;
        a_q    <= accept_id ? req1_a : req0_a;
        b_q    <= accept_id ? req1_b : req0_b;
        id_q   <= accept_id;
        last_q <= accept_id;
      end
      if (state_q == StExec) begin
        result_q <= alu_res;
        carry_q  <= alu_c;
        ovf_q    <= alu_v;
        zero_q   <= alu_z;
      end
      if ((state_q == StResp) && resp_ready) begin
        if (id_q) cnt1_q <= cnt1_q + 1'b1;
        else      cnt0_q <= cnt0_q + 1'b1;
      end
    end
  end

  assign resp_valid    = (state_q == StResp);
  assign resp_id       = id_q;
  assign resp_result   = result_q;
  assign resp_carry    = carry_q;
  assign resp_overflow = ovf_q;
  assign resp_zero     = zero_q;
  assign done_cnt0     = cnt0_q;
  assign done_cnt1     = cnt1_q;

endmodule
